// File: rtl/lane_packer.sv
// Packs a stream of DATA_WIDTH elements into LANES-wide words, closing a word early on in_last.
// A completed group goes straight to the output register when it is free, otherwise it waits in staging.
module lane_packer #(
  parameter int DATA_WIDTH    = 12,
  parameter int LANES         = 6,
  parameter int COUNTER_WIDTH = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]              out_keep,
  output logic                          out_last,
  output logic                          step,
  output logic [COUNTER_WIDTH-1:0]      group_cnt
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [IDX_W-1:0]            idx;
  logic                        pend;
  logic                        stage_last;
  logic [LANES-1:0]            stage_keep;
  logic [DATA_WIDTH-1:0]       stage [LANES];
  logic                        in_fire;
  logic                        slot_free;
  logic                        complete;
  logic [LANES*DATA_WIDTH-1:0] merged_data;
  logic [LANES-1:0]            merged_keep;
  logic [LANES*DATA_WIDTH-1:0] staged_data;

  assign in_ready  = !pend;
  assign in_fire   = in_valid && !pend;
  assign slot_free = !out_valid || out_ready;
  assign complete  = in_fire && ((idx == IDX_W'(LANES - 1)) || in_last);
  assign step      = out_valid && out_ready;

  // staged_data is the held group alone; merged_data also folds in the element arriving now.
  always_comb begin
    merged_data = '0;
    staged_data = '0;
    merged_keep = stage_keep;
    for (int k = 0; k < LANES; k++) begin
      if (stage_keep[k]) begin
        merged_data[k*DATA_WIDTH +: DATA_WIDTH] = stage[k];
        staged_data[k*DATA_WIDTH +: DATA_WIDTH] = stage[k];
      end
      if (k == int'(idx)) begin
        merged_data[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
        merged_keep[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      pend       <= 1'b0;
      idx        <= '0;
      group_cnt  <= '0;
      stage_keep <= '0;
      stage_last <= 1'b0;
    end else begin
      if (step) begin
        group_cnt <= group_cnt + COUNTER_WIDTH'(1);
      end
      // A pending group blocks input, so it never competes with a new completion.
      if (pend && slot_free) begin
        out_valid  <= 1'b1;
        out_data   <= staged_data;
        out_keep   <= stage_keep;
        out_last   <= stage_last;
        pend       <= 1'b0;
        idx        <= '0;
        stage_keep <= '0;
      end else if (complete && slot_free) begin
        out_valid  <= 1'b1;
        out_data   <= merged_data;
        out_keep   <= merged_keep;
        out_last   <= in_last;
        idx        <= '0;
        stage_keep <= '0;
      end else begin
        if (out_ready) begin
          out_valid <= 1'b0;
        end
        if (in_fire) begin
          stage[idx]      <= in_data;
          stage_keep[idx] <= 1'b1;
          if (complete) begin
            pend       <= 1'b1;
            stage_last <= in_last;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
      end
    end
  end

endmodule
